// File: rtl/clock_card_reader_if.sv
// Slot-bus and request/result bundle between the clock card reader and its surroundings.
// The master modport is the reader. The slave modport is the slot bus mux, the card and the host side.
interface clock_card_reader_if;
  logic        START;
  logic [15:0] ADDRESS;
  logic        RW_N;
  logic        DEVICE_SELECT_N;
  logic [7:0]  CARD_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [1:0]  RETRIES;
  logic [64:0] RTC_OUT;

  modport master (
    input  START,
    input  CARD_DATA,
    output ADDRESS,
    output RW_N,
    output DEVICE_SELECT_N,
    output BUSY,
    output DONE,
    output ERROR,
    output RETRIES,
    output RTC_OUT
  );

  modport slave (
    output START,
    output CARD_DATA,
    input  ADDRESS,
    input  RW_N,
    input  DEVICE_SELECT_N,
    input  BUSY,
    input  DONE,
    input  ERROR,
    input  RETRIES,
    input  RTC_OUT
  );
endinterface

// File: rtl/clock_card_reader.sv
// Clock card reader.
// This block polls the clock card registers C0C0..C0CE over the slot bus and packs them into the 65-bit RTC vector.
// Bit 64 of the vector toggles on every successful snapshot.
// Each pass is bracketed by two reads of SECONDS_ONES: one before the pass and one at its end.
// A difference between those two reads means the time rolled over during the pass, so the pass is retried.
// Optional macro CLOCK_READER_CHECK_EN: when defined, the fixed upper bits of every sample are validated.
// Any invalid sample abandons the snapshot with ERROR.
module clock_card_reader #(
  parameter int WAIT_CYCLES = 3,
  parameter int MAX_RETRY   = 3
) (
  input logic                 CLK_14M,
  input logic                 RESET_N,
  clock_card_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEL, GAP, CHECK} state_t;

  localparam logic [3:0] SEC_ONES_IDX = 4'd14;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [3:0]  pre_sec_q, pre_sec_d;
  logic [50:0] shadow_q, shadow_d;
  logic [64:0] rtc_q, rtc_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  retries_q, retries_d;

  logic        sample_last;
  logic        chk_fail;
  logic        pass_ok;
  logic        can_retry;

  // Place one card register value into its field of the shadow vector.
  function automatic logic [50:0] pack_field(input logic [50:0] s, input logic [3:0] idx,
                                             input logic [7:0] d);
    logic [50:0] r;
    r = s;
    case (idx)
      4'd2:    r[47:44] = d[3:0];
      4'd3:    r[43:40] = d[3:0];
      4'd4:    r[36]    = d[0];
      4'd5:    r[35:32] = d[3:0];
      4'd6:    r[50:48] = d[2:0];
      4'd7:    r[29:28] = d[1:0];
      4'd8:    r[27:24] = d[3:0];
      4'd9:    r[21:20] = d[1:0];
      4'd10:   r[19:16] = d[3:0];
      4'd11:   r[14:12] = d[2:0];
      4'd12:   r[11:8]  = d[3:0];
      4'd13:   r[6:4]   = d[2:0];
      4'd14:   r[3:0]   = d[3:0];
      default: r = s;
    endcase
    return r;
  endfunction

  assign sample_last = (state_q == SEL) && (cnt_q == 8'(WAIT_CYCLES));
  assign pass_ok     = !chk_fail && (pre_sec_q == shadow_q[3:0]);
  assign can_retry   = !chk_fail && (retry_q < 8'(MAX_RETRY));

`ifdef CLOCK_READER_CHECK_EN
  logic chk_fail_q, chk_fail_d;

  // Returns 1 when the fixed upper bits of a card register hold their expected constant.
  function automatic logic upper_ok(input logic [3:0] idx, input logic [7:0] d);
    logic ok;
    case (idx)
      4'd0:                                       ok = (d == 8'h32);
      4'd1:                                       ok = (d == 8'h30);
      4'd2, 4'd3, 4'd5, 4'd8, 4'd10, 4'd12, 4'd14: ok = (d[7:4] == 4'h3);
      4'd4:                                       ok = (d[7:1] == 7'h18);
      4'd6, 4'd11, 4'd13:                         ok = (d[7:3] == 5'h06);
      4'd7, 4'd9:                                 ok = (d[7:2] == 6'h0C);
      default:                                    ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Latch a fail flag on any malformed sample. The flag clears while no pass is running.
  always_comb begin
    chk_fail_d = chk_fail_q;
    if (state_q == IDLE || state_q == CHECK) chk_fail_d = 1'b0;
    else if (sample_last && !upper_ok(idx_q, bus.CARD_DATA)) chk_fail_d = 1'b1;
  end

  // Fail flag register.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) chk_fail_q <= 1'b0;
    else          chk_fail_q <= chk_fail_d;
  end

  assign chk_fail = chk_fail_q;
`else
  logic unused_upper;
  assign unused_upper = ^bus.CARD_DATA[7:4];
  assign chk_fail     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = SEL;
      SEL:     if (sample_last) state_d = GAP;
      GAP:     state_d = (!pre_q && idx_q == SEC_ONES_IDX) ? CHECK : SEL;
      CHECK:   state_d = (!pass_ok && can_retry) ? SEL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: drive the slot bus only while a read is selected.
  always_comb begin
    bus.ADDRESS         = 16'h0000;
    bus.DEVICE_SELECT_N = 1'b1;
    bus.BUSY            = (state_q != IDLE);
    if (state_q == SEL) begin
      bus.ADDRESS         = 16'hC0C0 + {12'h000, idx_q};
      bus.DEVICE_SELECT_N = 1'b0;
    end
  end

  assign bus.RW_N    = 1'b1;
  assign bus.DONE    = done_q;
  assign bus.ERROR   = error_q;
  assign bus.RETRIES = retries_q;
  assign bus.RTC_OUT = rtc_q;

  // Datapath: sequence the reads, stage the samples, and resolve each pass in CHECK.
  always_comb begin
    idx_d     = idx_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pre_sec_d = pre_sec_q;
    shadow_d  = shadow_q;
    rtc_d     = rtc_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    retries_d = retries_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          idx_d    = SEC_ONES_IDX;
          pre_d    = 1'b1;
          cnt_d    = 8'd0;
          retry_d  = 8'd0;
          shadow_d = '0;
        end
      end
      SEL: begin
        if (sample_last) begin
          cnt_d = 8'd0;
          if (pre_q) pre_sec_d = bus.CARD_DATA[3:0];
          else       shadow_d  = pack_field(shadow_q, idx_q, bus.CARD_DATA);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (pre_q) begin
          idx_d = 4'd0;
          pre_d = 1'b0;
        end else if (idx_q != SEC_ONES_IDX) begin
          idx_d = idx_q + 4'd1;
        end
      end
      CHECK: begin
        if (pass_ok) begin
          rtc_d     = {~rtc_q[64], 13'h0000, shadow_q};
          done_d    = 1'b1;
          retries_d = (retry_q > 8'(MAX_RETRY)) ? 2'(MAX_RETRY) : retry_q[1:0];
        end else if (can_retry) begin
          retry_d = retry_q + 8'd1;
          idx_d   = SEC_ONES_IDX;
          pre_d   = 1'b1;
        end else begin
          error_d   = 1'b1;
          retries_d = (retry_q > 8'(MAX_RETRY)) ? 2'(MAX_RETRY) : retry_q[1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. All of them clear on reset, so an aborted pass leaves RTC_OUT at zero.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q     <= 4'd0;
      pre_q     <= 1'b0;
      cnt_q     <= 8'd0;
      retry_q   <= 8'd0;
      pre_sec_q <= 4'd0;
      shadow_q  <= '0;
      rtc_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      retries_q <= 2'd0;
    end else begin
      idx_q     <= idx_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pre_sec_q <= pre_sec_d;
      shadow_q  <= shadow_d;
      rtc_q     <= rtc_d;
      done_q    <= done_d;
      error_q   <= error_d;
      retries_q <= retries_d;
    end
  end

endmodule

// File: tb/tb_clock_card_reader.sv
// Testbench for clock_card_reader.
// A clock-card model answers slot-bus reads. A time-level reference model predicts the packed vector, the outcome and the latency.
module tb_clock_card_reader;

  localparam int WAIT_CYCLES = 3;
  localparam int MAX_RETRY   = 3;
  localparam int PASS_CYC    = 16 * (WAIT_CYCLES + 2) + 1;

  logic CLK_14M = 1'b0;
  logic RESET_N = 1'b0;

  clock_card_reader_if bus_if ();

  clock_card_reader #(.WAIT_CYCLES(WAIT_CYCLES), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK_14M (CLK_14M),
    .RESET_N (RESET_N),
    .bus     (bus_if)
  );

  always #5 CLK_14M = ~CLK_14M;

  typedef struct {
    int yr; int mon; int day; int dow; int hr; int mn; int sec;
    int roll;
    bit exp_done;
    int exp_retries;
    int exp_lat;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Clock card model.
  logic [7:0] card_mem [16];
  int         sec_ones   = 0;
  int         bumps      = 0;
  int         bump_base  = 0;
  int         n14        = 0;
  int         n14_base   = 0;
  int         roll_limit = 0;
  logic       in14_prev  = 1'b0;
  logic       in14_now;
  logic [3:0] sec_nib;
  logic [7:0] card_byte;

  assign in14_now = !bus_if.DEVICE_SELECT_N && (bus_if.ADDRESS == 16'hC0CE);
  assign sec_nib  = 4'((sec_ones + bumps - bump_base) % 10);

  always_comb begin
    card_byte = 8'hFF;
    if (!bus_if.DEVICE_SELECT_N && bus_if.ADDRESS[15:4] == 12'hC0C) begin
      card_byte = card_mem[bus_if.ADDRESS[3:0]];
      if (bus_if.ADDRESS[3:0] == 4'd14) card_byte = {4'h3, sec_nib};
    end
  end
  assign bus_if.CARD_DATA = card_byte;

  // Seconds rollover: this happens right after the pre-read of pass j, for every j <= roll_limit.
  always @(negedge CLK_14M) begin
    in14_prev <= in14_now;
    if (in14_prev && !in14_now) begin
      n14 <= n14 + 1;
      if (((n14 + 1 - n14_base) % 2 == 1) && ((n14 + 2 - n14_base) / 2 <= roll_limit))
        bumps <= bumps + 1;
    end
  end

  // Reference state.
  logic [64:0] model_rtc = '0;
  logic        model_tog = 1'b0;

  function automatic logic [64:0] model_pack(input logic tog, input vec_t v, input int sec);
    logic [64:0] r;
    r = '0;
    r[64]    = tog;
    r[50:48] = 3'(v.dow);
    r[47:44] = 4'(v.yr / 10);   r[43:40] = 4'(v.yr % 10);
    r[36]    = 1'(v.mon / 10);  r[35:32] = 4'(v.mon % 10);
    r[29:28] = 2'(v.day / 10);  r[27:24] = 4'(v.day % 10);
    r[21:20] = 2'(v.hr / 10);   r[19:16] = 4'(v.hr % 10);
    r[14:12] = 3'(v.mn / 10);   r[11:8]  = 4'(v.mn % 10);
    r[6:4]   = 3'(sec / 10);    r[3:0]   = 4'(sec % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_time(input vec_t v);
    card_mem[0]  = 8'h32;
    card_mem[1]  = 8'h30;
    card_mem[2]  = 8'h30 | 8'(v.yr / 10);
    card_mem[3]  = 8'h30 | 8'(v.yr % 10);
    card_mem[4]  = 8'h30 | 8'(v.mon / 10);
    card_mem[5]  = 8'h30 | 8'(v.mon % 10);
    card_mem[6]  = 8'h30 | 8'(v.dow);
    card_mem[7]  = 8'h30 | 8'(v.day / 10);
    card_mem[8]  = 8'h30 | 8'(v.day % 10);
    card_mem[9]  = 8'h30 | 8'(v.hr / 10);
    card_mem[10] = 8'h30 | 8'(v.hr % 10);
    card_mem[11] = 8'h30 | 8'(v.mn / 10);
    card_mem[12] = 8'h30 | 8'(v.mn % 10);
    card_mem[13] = 8'h30 | 8'(v.sec / 10);
    card_mem[14] = 8'h30 | 8'(v.sec % 10);
    card_mem[15] = 8'h30;
    sec_ones   = v.sec % 10;
    bump_base  = bumps;
    n14_base   = n14;
    roll_limit = v.roll;
  endtask

  task automatic fill_expect(inout vec_t v);
    if (v.roll <= MAX_RETRY) begin
      v.exp_done = 1'b1; v.exp_retries = v.roll; v.exp_lat = (v.roll + 1) * PASS_CYC;
    end else begin
      v.exp_done = 1'b0; v.exp_retries = MAX_RETRY; v.exp_lat = (MAX_RETRY + 1) * PASS_CYC;
    end
  endtask

  task automatic start_pulse();
    @(negedge CLK_14M);
    bus_if.START = 1'b1;
    @(posedge CLK_14M);
    #1 bus_if.START = 1'b0;
  endtask

  // Run one snapshot whose card contents are already loaded, and compare the result against the reference.
  task automatic run_loaded(input string tag, input vec_t v);
    bit got; bit got_done; bit got_err; int lat; int sec_final;
    got = 0; got_done = 0; got_err = 0; lat = 0;
    start_pulse();
    for (int n = 1; n <= 600 && !got; n++) begin
      @(posedge CLK_14M);
      #1;
      if (n == 1) begin
        chk({tag, " addr_pre"}, 128'(bus_if.ADDRESS), 128'(16'hC0CE));
        chk({tag, " dsel_pre"}, 128'(bus_if.DEVICE_SELECT_N), 128'(1'b0));
        chk({tag, " busy"}, 128'(bus_if.BUSY), 128'(1'b1));
      end
      if (n == 4) chk({tag, " gap_addr"}, 128'({bus_if.DEVICE_SELECT_N, bus_if.ADDRESS}), 128'(17'h10000));
      if (n == 5) chk({tag, " addr_idx0"}, 128'(bus_if.ADDRESS), 128'(16'hC0C0));
      if (n == 30) bus_if.START = 1'b1;
      if (n == 31) bus_if.START = 1'b0;
      if (bus_if.DONE || bus_if.ERROR) begin
        got = 1; lat = n; got_done = bus_if.DONE; got_err = bus_if.ERROR;
      end
    end
    bus_if.START = 1'b0;
    chk({tag, " finished"}, 128'(got), 128'(1'b1));
    if (v.exp_done) begin
      sec_final = (v.sec / 10) * 10 + (v.sec % 10 + v.roll) % 10;
      model_tog = ~model_tog;
      model_rtc = model_pack(model_tog, v, sec_final);
    end
    chk({tag, " latency"}, 128'(lat), 128'(v.exp_lat));
    chk({tag, " done"}, 128'(got_done), 128'(v.exp_done));
    chk({tag, " error"}, 128'(got_err), 128'(!v.exp_done));
    chk({tag, " retries"}, 128'(bus_if.RETRIES), 128'(v.exp_retries));
    chk({tag, " rtc"}, 128'(bus_if.RTC_OUT), 128'(model_rtc));
    @(posedge CLK_14M);
    #1;
    chk({tag, " pulse_end"}, 128'({bus_if.DONE, bus_if.ERROR, bus_if.BUSY}), 128'(3'b000));
  endtask

  task automatic run(input string tag, input vec_t v);
    set_time(v);
    run_loaded(tag, v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rst_busy"}, 128'(bus_if.BUSY), 128'(1'b0));
    chk({tag, " rst_pulses"}, 128'({bus_if.DONE, bus_if.ERROR}), 128'(2'b00));
    chk({tag, " rst_retries"}, 128'(bus_if.RETRIES), 128'(2'd0));
    chk({tag, " rst_rtc"}, 128'(bus_if.RTC_OUT), 128'(65'd0));
    chk({tag, " rst_bus"}, 128'({bus_if.RW_N, bus_if.DEVICE_SELECT_N, bus_if.ADDRESS}), 128'(18'h30000));
  endtask

  vec_t tbl [4];
  vec_t v;

  initial begin
    bus_if.START = 1'b0;
    tbl[0] = '{25, 3, 14, 5, 12, 34, 56, 0,  1'b1, 0, PASS_CYC};
    tbl[1] = '{25, 3, 14, 5, 12, 34, 56, 0,  1'b1, 0, PASS_CYC};
    tbl[2] = '{25, 3, 14, 5, 12, 34, 56, 1,  1'b1, 1, 2 * PASS_CYC};
    tbl[3] = '{25, 3, 14, 5, 12, 34, 56, 99, 1'b0, 3, 4 * PASS_CYC};

    v = tbl[0];
    set_time(v);
    repeat (3) @(posedge CLK_14M);
    #1 chk_reset_state("init");
    @(negedge CLK_14M) RESET_N = 1'b1;
    repeat (2) @(posedge CLK_14M);

    chk("first_vector", 128'(model_pack(1'b1, tbl[0], 56)), 128'(65'h1_0005_2503_1412_3456));

    for (int i = 0; i < 4; i++) run($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 8; i++) begin
      int r;
      v.yr  = int'($urandom_range(0, 99));
      v.mon = int'($urandom_range(1, 12));
      v.day = int'($urandom_range(1, 31));
      v.dow = int'($urandom_range(0, 6));
      v.hr  = int'($urandom_range(0, 23));
      v.mn  = int'($urandom_range(0, 59));
      v.sec = int'($urandom_range(0, 59));
      r = int'($urandom_range(0, 9));
      v.roll = (r < 5) ? 0 : r - 4;
      fill_expect(v);
      run($sformatf("rnd%0d", i), v);
    end

    // An asynchronous reset in the middle of a pass.
    v = tbl[0];
    set_time(v);
    start_pulse();
    repeat (40) @(posedge CLK_14M);
    #1 RESET_N = 1'b0;
    #1 chk_reset_state("midpass");
    model_rtc = '0;
    model_tog = 1'b0;
    @(negedge CLK_14M) RESET_N = 1'b1;
    repeat (2) @(posedge CLK_14M);
    run("after_reset", v);

    // A malformed upper byte in idx0.
    v = tbl[0];
    set_time(v);
    card_mem[0] = 8'h31;
`ifdef CLOCK_READER_CHECK_EN
    v.exp_done = 1'b0; v.exp_retries = 0; v.exp_lat = PASS_CYC;
`else
    v.exp_done = 1'b1; v.exp_retries = 0; v.exp_lat = PASS_CYC;
`endif
    run_loaded("upper_check", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
